clock_100_pll: RTL and testbench

//  Behavioural PLL: multiplies the 50 MHz board reference clk by 2 to produce the
//  100 MHz system/SDRAM clock outclk_0, and flags lock. It sits between the board

---
 rtl/clock_100_pll.sv | 122 ++++++++++++
 tb/tb_clock_100_pll.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_100_pll.sv
//==============================================================================
// Module      : clock_100_pll
// Description : Behavioural reference-clock multiplier with lock detection.
//               Measures the clk period on every rising edge, regenerates an
//               output clock at MULT x that rate, phase-aligned to clk, and
//               reports lock after LOCK_CYCLES consecutive stable periods.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ps/1ps
`default_nettype none

module clock_100_pll #(
    parameter int unsigned MULT        = 2,
    parameter int unsigned LOCK_CYCLES = 8,
    parameter int unsigned TOL_PS      = 100,
    parameter int unsigned TIMEOUT_PS  = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic outclk_0,
    output logic locked
);

    // Power-up state doubles as the auto-reset state when rst is tied low.
    logic        outclk_q      = 1'b0;
    logic        locked_q      = 1'b0;
    int unsigned lock_cnt_q    = 0;
    int unsigned epoch_q       = 0;     // bumped on every ref edge; stale jobs compare against it
    logic        have_prev_q   = 1'b0;  // a previous ref edge time is stored
    logic        have_period_q = 1'b0;  // a previous period is stored
    realtime     t_prev_q      = 0.0;
    realtime     period_q      = 0.0;

    assign outclk_0 = outclk_q;
    assign locked   = locked_q;

    // Launch one output cycle (rise at k*P/MULT, fall half a sub-period later).
    // Edges belonging to an older ref edge are dropped, which re-aligns or
    // cancels them when a newer edge, a reset or a timeout intervenes.
    task automatic schedule_edges(input int unsigned ep, input int unsigned k,
                                  input realtime p);
        longint rise_dly;
        longint half_dly;
        rise_dly = longint'(p * real'(k) / real'(MULT));
        half_dly = longint'(p / real'(2 * MULT));
        fork
            begin
                #(rise_dly);
                if (epoch_q == ep) begin
                    outclk_q = 1'b1;
                end
                #(half_dly);
                if (epoch_q == ep) begin
                    outclk_q = 1'b0;
                end
            end
        join_none
    endtask

    // Watchdog: if no newer ref edge arrives within TIMEOUT_PS, drop lock,
    // park the output low and restart measurement from scratch.
    task automatic arm_timeout(input int unsigned ep);
        fork
            begin
                #(TIMEOUT_PS);
                if (epoch_q == ep) begin
                    locked_q      = 1'b0;
                    outclk_q      = 1'b0;
                    lock_cnt_q    = 0;
                    have_prev_q   = 1'b0;
                    have_period_q = 1'b0;
                end
            end
        join_none
    endtask

    // Per ref edge: measure the period, update the lock counter, restart output generation.
    always begin : p_ref_edge
        realtime t_now;
        realtime p_new;
        realtime dev;
        @(posedge clk);
        t_now   = $realtime;
        epoch_q = epoch_q + 1;
        if (rst) begin
            locked_q      = 1'b0;
            outclk_q      = 1'b0;
            lock_cnt_q    = 0;
            have_prev_q   = 1'b0;
            have_period_q = 1'b0;
        end else if (!have_prev_q) begin
            // First edge after start: only a timestamp, nothing to generate yet.
            t_prev_q    = t_now;
            have_prev_q = 1'b1;
            outclk_q    = 1'b0;
            locked_q    = 1'b0;
        end else begin
            p_new    = t_now - t_prev_q;
            t_prev_q = t_now;
            dev      = (p_new > period_q) ? (p_new - period_q) : (period_q - p_new);
            // The very first period has nothing to compare with and counts as stable.
            if (!have_period_q || dev <= real'(TOL_PS)) begin
                if (lock_cnt_q < LOCK_CYCLES) begin
                    lock_cnt_q = lock_cnt_q + 1;
                end
            end else begin
                lock_cnt_q = 0;
            end
            period_q      = p_new;
            have_period_q = 1'b1;
            locked_q      = (lock_cnt_q >= LOCK_CYCLES);
            outclk_q      = 1'b1;
            for (int unsigned k = 0; k < MULT; k++) begin
                schedule_edges(epoch_q, k, p_new);
            end
        end
        arm_timeout(epoch_q);
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_100_pll.sv
//==============================================================================
// Module      : tb_clock_100_pll
// Description : Self-checking bench for clock_100_pll (MULT=2 and MULT=4
//               instances on a shared reference), compared against a
//               period-history model sampled on a fixed grid inside every
//               reference cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ps/1ps
`default_nettype none

module tb_clock_100_pll;

    localparam int LOCK_CYCLES = 8;
    localparam int TOL_PS      = 100;
    localparam int TIMEOUT_PS  = 100000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic out2, lk2, out4, lk4;

    clock_100_pll #(.MULT(2), .LOCK_CYCLES(LOCK_CYCLES), .TOL_PS(TOL_PS),
                    .TIMEOUT_PS(TIMEOUT_PS)) dut (
        .clk(clk), .rst(rst), .outclk_0(out2), .locked(lk2));

    clock_100_pll #(.MULT(4), .LOCK_CYCLES(LOCK_CYCLES), .TOL_PS(TOL_PS),
                    .TIMEOUT_PS(TIMEOUT_PS)) dut4 (
        .clk(clk), .rst(rst), .outclk_0(out4), .locked(lk4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t ps: got %b, expected %b", name, $realtime, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    real per_q[$];          // periods measured since the last (re)start
    bit  started = 0;
    bit  gen     = 0;       // output active during the current ref cycle
    bit  any_edge = 0;
    real t_last  = 0.0;
    real t_any   = 0.0;
    real t_edge  = 0.0;

    task automatic model_edge(input bit r);
        real t;
        t = $realtime;
        if (any_edge && (t - t_any) >= TIMEOUT_PS) begin
            per_q.delete();
            started = 0;
        end
        any_edge = 1;
        t_any    = t;
        if (r) begin
            per_q.delete();
            started = 0;
            gen     = 0;
        end else if (!started) begin
            started = 1;
            t_last  = t;
            gen     = 0;
        end else begin
            per_q.push_back(t - t_last);
            t_last = t;
            gen    = 1;
        end
    endtask

    function automatic bit model_locked(input real d);
        int  run;
        real diff;
        if (d >= TIMEOUT_PS) return 1'b0;
        run = 0;
        for (int i = 0; i < per_q.size(); i++) begin
            if (i == 0) begin
                run++;
            end else begin
                diff = per_q[i] - per_q[i-1];
                if (diff < 0.0) diff = -diff;
                if (diff <= TOL_PS) run++;
                else run = 0;
            end
        end
        return run >= LOCK_CYCLES;
    endfunction

    function automatic bit model_out(input int m, input real d);
        real p, sub, ph;
        if (!gen || d >= TIMEOUT_PS) return 1'b0;
        p = per_q[per_q.size()-1];
        if (d >= p) return 1'b0;
        sub = p / m;
        ph  = d - sub * $floor(d / sub);
        return ph < sub / 2.0;
    endfunction

    task automatic sample_all();
        real d;
        d = $realtime - t_edge;
        check("outclk_m2", out2, model_out(2, d));
        check("outclk_m4", out4, model_out(4, d));
        check("locked_m2", lk2, model_locked(d));
        check("locked_m4", lk4, model_locked(d));
    endtask

    // One reference period of len ps; rst is set 100 ps before the rising edge.
    task automatic ref_cycle(input int len, input bit r);
        rst = r;
        #100;
        clk = 1'b1;
        t_edge = $realtime;
        model_edge(r);
        for (int d = 300; d < len - 100; d += 1000) begin
            if (clk && d >= len / 2) begin
                #(t_edge + len / 2 - $realtime);
                clk = 1'b0;
            end
            #(t_edge + d - $realtime);
            sample_all();
        end
        if (clk) begin
            #(t_edge + len / 2 - $realtime);
            clk = 1'b0;
        end
        #(t_edge + len - 100 - $realtime);
    endtask

    // 20 ns cycle with hand-derived output levels pinned at 3 ns and 7 ns.
    task automatic pin_cycle();
        rst = 1'b0;
        #100;
        clk = 1'b1;
        t_edge = $realtime;
        model_edge(1'b0);
        #3000;
        check("pin_m2_hi_at_3ns", out2, 1'b1);
        check("pin_m4_lo_at_3ns", out4, 1'b0);
        sample_all();
        #4000;
        check("pin_m2_lo_at_7ns", out2, 1'b0);
        check("pin_m4_hi_at_7ns", out4, 1'b1);
        sample_all();
        #3000;
        clk = 1'b0;
        #9900;
    endtask

    initial begin
        int lens[3];
        lens[0] = 20000;
        lens[1] = 25000;
        lens[2] = 30000;

        #1;
        check("pwrup_outclk", out2, 1'b0);
        check("pwrup_locked", lk2, 1'b0);
        sample_all();

        // Reset, then lock on a 50 MHz reference.
        ref_cycle(20000, 1'b1);
        ref_cycle(20000, 1'b1);
        check("rst_locked", lk2, 1'b0);
        check("rst_outclk", out2, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            ref_cycle(20000, 1'b0);
            if (i == 8) check("lock_edge8_low", lk2, 1'b0);
            if (i == 9) begin
                check("lock_edge9_high", lk2, 1'b1);
                check("lock_m4_edge9_high", lk4, 1'b1);
            end
        end
        pin_cycle();

        // One-cycle reset while locked.
        ref_cycle(20000, 1'b1);
        check("midrst_locked", lk2, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            ref_cycle(20000, 1'b0);
            if (i == 8) check("relock_edge8_low", lk2, 1'b0);
            if (i == 9) check("relock_edge9_high", lk2, 1'b1);
        end

        // Frequency change 20 ns -> 25 ns.
        for (int i = 1; i <= 12; i++) begin
            ref_cycle(25000, 1'b0);
            if (i == 1)  check("fchg_still_locked", lk2, 1'b1);
            if (i == 2)  check("fchg_lock_drop", lk2, 1'b0);
            if (i == 9)  check("fchg_not_yet", lk2, 1'b0);
            if (i == 10) check("fchg_relock", lk2, 1'b1);
        end

        // Back to 20 ns, then +/-50 ps jitter must keep lock.
        for (int i = 0; i < 10; i++) ref_cycle(20000, 1'b0);
        for (int i = 0; i < 30; i++) ref_cycle(20000 + int'($urandom_range(0, 100)) - 50, 1'b0);
        check("jitter50_locked", lk2, 1'b1);

        // A 200 ps step drops lock; then random 200 ps jitter.
        ref_cycle(20000, 1'b0);
        ref_cycle(20200, 1'b0);
        ref_cycle(20000, 1'b0);
        check("jitter200_drop", lk2, 1'b0);
        for (int i = 0; i < 20; i++) ref_cycle(20000 + int'($urandom_range(0, 400)) - 200, 1'b0);

        // Reference stops for 150 ns, then restarts.
        for (int i = 0; i < 10; i++) ref_cycle(20000, 1'b0);
        ref_cycle(150000, 1'b0);
        check("stop_locked", lk2, 1'b0);
        check("stop_outclk", out2, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            ref_cycle(20000, 1'b0);
            if (i == 9) check("restart_relock", lk2, 1'b1);
        end

        // Randomised period runs with occasional resets.
        for (int seg = 0; seg < 10; seg++) begin
            int len;
            int n;
            len = lens[$urandom_range(0, 2)];
            n   = int'($urandom_range(3, 12));
            for (int i = 0; i < n; i++) ref_cycle(len, ($urandom_range(0, 11) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
